sar_search_4_bit: RTL and testbench

SAR_SEARCH_4_BIT -- requirements
Module: sar_search_4_bit

---
 rtl/sar_search_4_bit.sv | 173 +++++++++++++++++
 tb/tb_sar_search_4_bit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_4_bit.sv
// sar_search_4_bit: successive-approximation (binary) search over a 4-bit
// window, driving an external magnitude comparator (A = hidden target,
// B = cand) and narrowing [lo, hi] until the target is matched or excluded.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-high reset
//   start               launch a search (sampled only while idle)
//   range_lo/range_hi   inclusive search window, captured on accepted start
//   cmp_gt/cmp_lt/cmp_eq comparator flags for target vs cand
//   cand                registered probe value (comparator operand B)
//   busy                high whenever the engine is not idle
//   done                one-cycle completion pulse
//   result/found        matched value and its valid flag
//   err                 illegal window or illegal comparator flag set
//   steps               number of probes evaluated in the last/current search
module sar_search_4_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] range_lo,
  input  logic [3:0] range_hi,
  input  logic       cmp_gt,
  input  logic       cmp_lt,
  input  logic       cmp_eq,
  output logic [3:0] cand,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       found,
  output logic       err,
  output logic [2:0] steps
);

  localparam int unsigned DW = 4;
  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_lo, r_hi, r_cand, r_result;
  logic [DW-1:0] w_lo_nxt, w_hi_nxt, w_cand_nxt, w_result_nxt;
  logic [SW-1:0] r_steps, w_steps_nxt;
  logic          r_found, r_err, r_busy, r_done;
  logic          w_found_nxt, w_err_nxt, w_busy_nxt, w_done_nxt;
  logic [2:0]    w_flags;

  assign w_flags = {cmp_gt, cmp_lt, cmp_eq};

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_cand   <= '0;
      r_result <= '0;
      r_steps  <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_cand   <= w_cand_nxt;
      r_result <= w_result_nxt;
      r_steps  <= w_steps_nxt;
      r_found  <= w_found_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt  = r_state;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_cand_nxt   = r_cand;
    w_result_nxt = r_result;
    w_steps_nxt  = r_steps;
    w_found_nxt  = r_found;
    w_err_nxt    = r_err;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_steps_nxt = '0;
          w_found_nxt = 1'b0;
          if (range_lo <= range_hi) begin
            w_lo_nxt    = range_lo;
            w_hi_nxt    = range_hi;
            w_err_nxt   = 1'b0;
            w_state_nxt = S_DRIVE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end

      // Midpoint uses a 5-bit sum so lo+hi cannot overflow.
      S_DRIVE: begin
        w_cand_nxt  = DW'((5'(r_lo) + 5'(r_hi)) >> 1);
        w_state_nxt = S_SAMPLE;
      end

      // cand has been stable a full cycle; flags are now trustworthy.
      S_SAMPLE: begin
        w_steps_nxt = SW'(r_steps + SW'(1));
        case (w_flags)
          3'b001: begin
            w_result_nxt = r_cand;
            w_found_nxt  = 1'b1;
            w_state_nxt  = S_DONE;
          end
          3'b100: begin
            // Target above cand: stop at the top of the window, else raise lo.
            if (r_cand == r_hi) begin
              w_found_nxt = 1'b0;
              w_state_nxt = S_DONE;
            end else begin
              w_lo_nxt    = DW'(r_cand + DW'(1));
              w_state_nxt = S_DRIVE;
            end
          end
          3'b010: begin
            // Target below cand: stop at the bottom of the window, else lower hi.
            if (r_cand == r_lo) begin
              w_found_nxt = 1'b0;
              w_state_nxt = S_DONE;
            end else begin
              w_hi_nxt    = DW'(r_cand - DW'(1));
              w_state_nxt = S_DRIVE;
            end
          end
          default: begin
            w_err_nxt   = 1'b1;
            w_found_nxt = 1'b0;
            w_state_nxt = S_DONE;
          end
        endcase
      end

      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign cand   = r_cand;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign found  = r_found;
  assign err    = r_err;
  assign steps  = r_steps;

endmodule

// File: tb/tb_sar_search_4_bit.sv
// Self-checking bench for sar_search_4_bit: a behavioural comparator answers
// probes for a hidden target, and a binary-search model predicts the probe
// sequence, timing and final outputs of every search.
module tb_sar_search_4_bit;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] range_lo, range_hi;
  logic       cmp_gt, cmp_lt, cmp_eq;
  logic [3:0] cand, result;
  logic       busy, done, found, err;
  logic [2:0] steps;

  logic [3:0] target;
  logic       bad_mode;

  int tests = 0;
  int fails = 0;

  // Model expectations
  int exp_seq[$];
  int exp_steps, exp_found, exp_err;
  int model_result = 0;
  int obs_cand[$];
  int done_k;

  sar_search_4_bit dut (
    .clk(clk), .rst(rst), .start(start),
    .range_lo(range_lo), .range_hi(range_hi),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .cand(cand), .busy(busy), .done(done),
    .result(result), .found(found), .err(err), .steps(steps)
  );

  always #5 clk = ~clk;

  // Behavioural comparator; bad_mode raises gt and lt together.
  assign cmp_gt = bad_mode | (target > cand);
  assign cmp_lt = bad_mode | (target < cand);
  assign cmp_eq = !bad_mode && (target == cand);

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input int lo, input int hi, input int t, input bit bad);
    int c;
    exp_seq.delete();
    exp_steps = 0;
    exp_found = 0;
    exp_err   = 0;
    if (lo > hi) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      c = (lo + hi) / 2;
      exp_steps++;
      exp_seq.push_back(c);
      if (bad) begin exp_err = 1; break; end
      if (c == t) begin exp_found = 1; model_result = c; break; end
      if (t > c) begin
        if (c == hi) break;
        lo = c + 1;
      end else begin
        if (c == lo) break;
        hi = c - 1;
      end
    end
  endtask

  // Launch one search and check outputs on every falling edge until done.
  task automatic run_search(input int lo, input int hi, input int tgt,
                            input bit bad, input bit poke);
    int n;
    target   = 4'(tgt);
    bad_mode = bad;
    model(lo, hi, tgt, bad);
    n = 2 * exp_steps + 1;
    obs_cand.delete();
    done_k = -1;
    start    = 1'b1;
    range_lo = 4'(lo);
    range_hi = 4'(hi);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (poke && k == 2) begin
        start = 1'b1; range_lo = 4'd0; range_hi = 4'd15;
      end
      if (poke && k == 3) start = 1'b0;
      if (done === 1'b1 && done_k < 0) done_k = k;
      check("busy", int'(busy), (k < n) ? 1 : 0);
      check("done", int'(done), (k == n) ? 1 : 0);
      if ((k % 2) == 1 && k < n - 1) begin
        obs_cand.push_back(int'(cand));
        check("cand", int'(cand), exp_seq[(k - 1) / 2]);
      end
      if (k == n) begin
        check("found",  int'(found),  exp_found);
        check("err",    int'(err),    exp_err);
        check("steps",  int'(steps),  exp_steps);
        check("result", int'(result), model_result);
      end
    end
    bad_mode = 1'b0;
  endtask

  task automatic check_seq(input string name, input int e[$]);
    check({name, "_len"}, obs_cand.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < obs_cand.size()) check(name, obs_cand[i], e[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cand"},   int'(cand),   0);
    check({tag, "_busy"},   int'(busy),   0);
    check({tag, "_done"},   int'(done),   0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_found"},  int'(found),  0);
    check({tag, "_err"},    int'(err),    0);
    check({tag, "_steps"},  int'(steps),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int lo, hi, t;
    rst = 1'b1; start = 1'b0; range_lo = '0; range_hi = '0;
    target = '0; bad_mode = 1'b0;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    #1 rst = 1'b0;

    // Target 7 in 0..15: single probe
    run_search(0, 15, 7, 0, 0);
    q = '{7}; check_seq("seq_t7", q);
    check("t7_found", int'(found), 1);
    check("t7_result", int'(result), 7);
    check("t7_steps", int'(steps), 1);
    check("t7_done_k", done_k, 3);

    // Target 15: climbs to top of window
    run_search(0, 15, 15, 0, 0);
    q = '{7, 11, 13, 14, 15}; check_seq("seq_t15", q);
    check("t15_result", int'(result), 15);
    check("t15_steps", int'(steps), 5);
    check("t15_done_k", done_k, 11);

    // Target 0: descends to bottom without wrap
    run_search(0, 15, 0, 0, 0);
    q = '{7, 3, 1, 0}; check_seq("seq_t0", q);
    check("t0_found", int'(found), 1);
    check("t0_result", int'(result), 0);
    check("t0_steps", int'(steps), 4);

    // Target outside 4..9
    run_search(4, 9, 12, 0, 0);
    q = '{6, 8, 9}; check_seq("seq_out", q);
    check("out_found", int'(found), 0);
    check("out_err", int'(err), 0);
    check("out_steps", int'(steps), 3);

    // Illegal window
    run_search(10, 3, 5, 0, 0);
    check("win_err", int'(err), 1);
    check("win_steps", int'(steps), 0);
    check("win_done_k", done_k, 1);

    // Illegal flag combination on first probe
    run_search(0, 15, 5, 1, 0);
    check("flag_err", int'(err), 1);
    check("flag_found", int'(found), 0);
    check("flag_steps", int'(steps), 1);

    // start pulsed while busy must be ignored
    run_search(0, 15, 13, 0, 1);
    check("poke_result", int'(result), 13);

    // Reset during the second probe
    target = 4'd15;
    start = 1'b1; range_lo = 4'd0; range_hi = 4'd15;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_cand", int'(cand), 11);
    #2 rst = 1'b1;
    #1 check_reset_vals("mid_rst");
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", int'(done), 0);
    end
    model_result = 0;
    #1 rst = 1'b0;
    run_search(0, 15, 3, 0, 0);

    // Randomized windows and targets
    for (int i = 0; i < 60; i++) begin
      lo = int'($urandom_range(0, 15));
      hi = int'($urandom_range(0, 15));
      if (($urandom % 8) != 0 && lo > hi) begin
        t = lo; lo = hi; hi = t;
      end
      t = int'($urandom_range(0, 15));
      run_search(lo, hi, t, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
